// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Valid/ready handshake on input and output; result valid BIN_W edges after
// the accepting edge. Values above 10^DIGITS-1 flag ovf and saturate to all 9s.
// Optional: LEADING_ZERO_BLANK_EN replaces leading zero digits with 4'hF.
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 30,
  parameter int unsigned DIGITS = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  function automatic logic [63:0] pow10_minus1(input int unsigned n);
    logic [63:0] v;
    v = 64'd1;
    for (int unsigned i = 0; i < n; i++) v = v * 64'd10;
    return v - 64'd1;
  endfunction

  localparam logic [63:0]      MAX_VAL = pow10_minus1(DIGITS);
  localparam logic [BCD_W-1:0] SAT_VAL = {DIGITS{4'h9}};

`ifdef LEADING_ZERO_BLANK_EN
  // Blank zero digits from the MSB down until the first non-zero; digit 0 is kept.
  function automatic logic [BCD_W-1:0] blank_lz(input logic [BCD_W-1:0] v);
    logic lead;
    blank_lz = v;
    lead     = 1'b1;
    for (int unsigned d = DIGITS - 1; d >= 1; d--) begin
      if (lead && (v[4*d +: 4] == 4'd0)) blank_lz[4*d +: 4] = 4'hF;
      else                               lead = 1'b0;
    end
  endfunction
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_next;
  logic [BIN_W-1:0]   bin_reg, bin_next;
  logic [BCD_W-1:0]   bcd_acc, acc_next, adj, load_val;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_pend;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One double-dabble step: add 3 to digits >= 5, then shift the binary MSB in.
  // The carry out of the top digit falls off in the truncating cast.
  always_comb begin
    adj = bcd_acc;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (bcd_acc[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd_acc[4*d +: 4] + 4'd3;
    end
    acc_next = BCD_W'({adj, bin_reg[BIN_W-1]});
    bin_next = {bin_reg[BIN_W-2:0], 1'b0};
`ifdef LEADING_ZERO_BLANK_EN
    load_val = ovf_pend ? SAT_VAL : blank_lz(acc_next);
`else
    load_val = ovf_pend ? SAT_VAL : acc_next;
`endif
  end

  // Datapath: load on accept, shift while converting, register the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_reg  <= '0;
      bcd_acc  <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      bcd_out  <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin_reg  <= bin_in;
            bcd_acc  <= '0;
            cnt      <= '0;
            ovf_pend <= (64'(bin_in) > MAX_VAL);
          end
        end
        SHIFT: begin
          bin_reg <= bin_next;
          bcd_acc <= acc_next;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            bcd_out <= load_val;
            ovf     <= ovf_pend;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table plus handshake/reset corner sequences.
module tb_bin2bcd_seq;

  localparam int unsigned BIN_W  = 30;
  localparam int unsigned DIGITS = 9;
  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned LAT    = 30;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [BIN_W-1:0]   bin_in;
  logic               out_valid;
  logic               out_ready;
  logic [BCD_W-1:0]   bcd_out;
  logic               ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [BCD_W-1:0] bcd;
    logic             ovf;
  } exp_t;

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic [BCD_W-1:0] bcd;
    logic             ovf;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_in    (bin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_out   (bcd_out),
    .ovf       (ovf)
  );

  // Decimal digits by repeated division, zero-padded.
  function automatic logic [BCD_W-1:0] model(input logic [BIN_W-1:0] v);
    longint unsigned x;
    logic [BCD_W-1:0] r;
    x = longint'(v);
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // What the display bus should carry for a plain BCD value.
  function automatic logic [BCD_W-1:0] shown(input logic [BCD_W-1:0] plain, input logic o);
    logic [BCD_W-1:0] r;
    r = plain;
    if (o) r = {DIGITS{4'h9}};
`ifdef LEADING_ZERO_BLANK_EN
    else begin
      int top;
      top = 0;
      for (int i = 0; i < DIGITS; i++) if (plain[4*i +: 4] != 4'd0) top = i;
      for (int i = 0; i < DIGITS; i++) if (i > top) r[4*i +: 4] = 4'hF;
    end
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [BCD_W-1:0] plain, input logic o);
    exp_t e;
    e.bcd = shown(plain, o);
    e.ovf = o;
    sb.push_back(e);
  endtask

  // Present one value for exactly one accepting edge.
  task automatic accept(input logic [BIN_W-1:0] v);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    bin_in   = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_in_ready", 64'(in_ready), 64'd0);
  endtask

  // Count edges until out_valid, then compare against the scoreboard head.
  task automatic collect(input bit jitter);
    int   n;
    exp_t e;
    n = 0;
    do begin
      if (jitter) begin
        bin_in   = BIN_W'($urandom);
        in_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 100);
    in_valid = 1'b0;
    check("latency", 64'(n), 64'(LAT));
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("scoreboard_empty", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("bcd_out", 64'(bcd_out), 64'(e.bcd));
        check("ovf", 64'(ovf), 64'(e.ovf));
      end
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs_out_valid", 64'(out_valid), 64'd0);
    check("hs_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BCD_W-1:0] exp42;
    logic [BIN_W-1:0] rv;

    vecs[0] = '{30'd0,          36'h000000000, 1'b0};
    vecs[1] = '{30'd123456789,  36'h123456789, 1'b0};
    vecs[2] = '{30'd999999999,  36'h999999999, 1'b0};
    vecs[3] = '{30'd1073741823, 36'h999999999, 1'b1};
    vecs[4] = '{30'd1000000000, 36'h999999999, 1'b1};
    vecs[5] = '{30'd7,          36'h000000007, 1'b0};
    vecs[6] = '{30'd10,         36'h000000010, 1'b0};
    vecs[7] = '{30'd100000000,  36'h100000000, 1'b0};
    vecs[8] = '{30'd5,          36'h000000005, 1'b0};

    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bin_in    = '0;

    // Reset values
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_bcd_out", 64'(bcd_out), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Vector table
    for (int i = 0; i < 9; i++) begin
      push_exp(vecs[i].bcd, vecs[i].ovf);
      accept(vecs[i].bin);
      collect(1'b0);
      handshake();
    end

    // Random in-range values against the division model
    for (int i = 0; i < 4; i++) begin
      rv = BIN_W'($urandom_range(0, 999999999));
      push_exp(model(rv), 1'b0);
      accept(rv);
      collect(1'b0);
      handshake();
    end

    // Output stall: DONE holds, in_valid ignored
    exp42 = shown(36'h000000042, 1'b0);
    push_exp(36'h000000042, 1'b0);
    accept(30'd42);
    collect(1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      bin_in   = 30'd99;
      @(posedge clk); #1;
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_bcd_out", 64'(bcd_out), 64'(exp42));
    end
    bin_in    = 30'd3;
    out_ready = 1'b1;
    push_exp(36'h000000003, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall_hs_out_valid", 64'(out_valid), 64'd0);
    check("stall_hs_in_ready", 64'(in_ready), 64'd1);
    check("held_bcd_out", 64'(bcd_out), 64'(exp42));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("next_accepted", 64'(in_ready), 64'd0);
    collect(1'b0);
    handshake();

    // Reset in the middle of a conversion
    accept(30'd987654321);
    repeat (14) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_bcd_out", 64'(bcd_out), 64'd0);
    check("midrst_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    push_exp(36'h000000007, 1'b0);
    accept(30'd7);
    collect(1'b0);
    handshake();

    // Input churn while shifting
    push_exp(36'h000005000, 1'b0);
    accept(30'd5000);
    collect(1'b1);
    handshake();

    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
